// File: rtl/feature_receiver_spi_if.sv
// feature_receiver_spi_if: SPI link inputs, feature stream handshake and per-frame status.
interface feature_receiver_spi_if #(
  parameter int FEATURE_WIDTH = 16,
  parameter int COUNT_WIDTH = 8
);
  logic spiSck;
  logic spiMosi;
  logic spiTransferDone;
  logic [FEATURE_WIDTH-1:0] featureVector;
  logic featureValid;
  logic featureReady;
  logic frameDone;
  logic [COUNT_WIDTH-1:0] frameFeatureCount;
  logic frameErrorPartial;
  logic frameErrorOverflow;
  modport slave (
    input  spiSck, spiMosi, spiTransferDone, featureReady,
    output featureVector, featureValid, frameDone, frameFeatureCount, frameErrorPartial, frameErrorOverflow
  );
  modport master (
    output spiSck, spiMosi, spiTransferDone, featureReady,
    input  featureVector, featureValid, frameDone, frameFeatureCount, frameErrorPartial, frameErrorOverflow
  );
endinterface

// File: rtl/feature_receiver_spi.sv
// feature_receiver_spi: oversampling SPI receiver feeding a show-ahead feature FIFO with per-frame status.
module feature_receiver_spi #(
  parameter int NUM_BITS_X = 4,
  parameter int NUM_BITS_Y = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int COUNT_WIDTH = 8
) (
  input logic systemClock,
  input logic reset,
  feature_receiver_spi_if.slave bus
);
  localparam int FW = (NUM_BITS_X + NUM_BITS_Y) * 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(FW);
  logic [1:0] r_sck_s, r_mosi_s, r_done_s;
  logic r_sck_prev, r_done_prev, r_sck_rise, r_done_rise, r_mosi_d;
  logic [FW-2:0] r_shift;
  logic [BW-1:0] r_bits;
  logic [COUNT_WIDTH-1:0] r_words, r_frame_count;
  logic r_ovf, r_frame_done, r_err_partial, r_err_ovf;
  logic [FW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_cnt;
  logic [FW-1:0] w_word;
  logic [BW-1:0] w_bits_nx;
  logic [COUNT_WIDTH-1:0] w_words_nx;
  logic w_last, w_full, w_valid, w_pop, w_wr, w_ovf_nx;
  // Edge strobes are registered once more so a word lands 4 edges after the pin
  assign w_word = {r_shift, r_mosi_d};
  assign w_last = r_sck_rise && r_bits == BW'(FW - 1);
  assign w_full = r_cnt == (AW + 1)'(FIFO_DEPTH);
  assign w_valid = r_cnt != '0;
  assign w_pop = w_valid && bus.featureReady;
  assign w_wr = w_last && (!w_full || w_pop);
  assign w_bits_nx = r_sck_rise ? (w_last ? '0 : r_bits + 1'b1) : r_bits;
  assign w_words_nx = (w_last && r_words != '1) ? r_words + 1'b1 : r_words;
  assign w_ovf_nx = r_ovf || (w_last && w_full && !w_pop);
  always_ff @(posedge systemClock) begin
    if (reset) begin
      r_sck_s <= '0;
      r_mosi_s <= '0;
      r_done_s <= '0;
      r_sck_prev <= 1'b0;
      r_done_prev <= 1'b0;
      r_sck_rise <= 1'b0;
      r_done_rise <= 1'b0;
      r_mosi_d <= 1'b0;
      r_shift <= '0;
      r_bits <= '0;
      r_words <= '0;
      r_ovf <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_count <= '0;
      r_err_partial <= 1'b0;
      r_err_ovf <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_sck_s <= {r_sck_s[0], bus.spiSck};
      r_mosi_s <= {r_mosi_s[0], bus.spiMosi};
      r_done_s <= {r_done_s[0], bus.spiTransferDone};
      r_sck_prev <= r_sck_s[1];
      r_done_prev <= r_done_s[1];
      r_sck_rise <= r_sck_s[1] && !r_sck_prev;
      r_done_rise <= r_done_s[1] && !r_done_prev;
      r_mosi_d <= r_mosi_s[1];
      if (r_sck_rise) r_shift <= w_word[FW-2:0];
      r_frame_done <= r_done_rise;
      if (r_done_rise) begin
        r_frame_count <= w_words_nx;
        r_err_partial <= w_bits_nx != '0;
        r_err_ovf <= w_ovf_nx;
      end
      r_bits <= r_done_rise ? '0 : w_bits_nx;
      r_words <= r_done_rise ? '0 : w_words_nx;
      r_ovf <= r_done_rise ? 1'b0 : w_ovf_nx;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt <= r_cnt + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
    end
  end
  always_ff @(posedge systemClock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end
  assign bus.featureValid = w_valid;
  assign bus.featureVector = w_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.frameDone = r_frame_done;
  assign bus.frameFeatureCount = r_frame_count;
  assign bus.frameErrorPartial = r_err_partial;
  assign bus.frameErrorOverflow = r_err_ovf;
endmodule

// File: tb/tb_feature_receiver_spi.sv
// tb_feature_receiver_spi: directed bench for the SPI feature receiver.
module tb_feature_receiver_spi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  feature_receiver_spi_if #(.FEATURE_WIDTH(16), .COUNT_WIDTH(8)) bus ();
  feature_receiver_spi #(.NUM_BITS_X(4), .NUM_BITS_Y(4), .FIFO_DEPTH(8), .COUNT_WIDTH(8)) dut (
    .systemClock(clk),
    .reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    bus.spiMosi = b;
    repeat (3) @(negedge clk);
    bus.spiSck = 1'b1;
    repeat (3) @(negedge clk);
    bus.spiSck = 1'b0;
  endtask
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic close_frame(input string tag, input int cnt, input logic part, input logic ovf);
    int pulses;
    pulses = 0;
    bus.spiTransferDone = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.frameDone) pulses++;
    end
    bus.spiTransferDone = 1'b0;
    chk({tag, "_done_pulses"}, pulses, 1);
    chk({tag, "_count"}, bus.frameFeatureCount, cnt);
    chk({tag, "_partial"}, bus.frameErrorPartial, part);
    chk({tag, "_overflow"}, bus.frameErrorOverflow, ovf);
    repeat (4) @(negedge clk);
  endtask
  task automatic pop_check(input string tag, input logic [15:0] exp);
    chk({tag, "_valid"}, bus.featureValid, 1'b1);
    chk({tag, "_vector"}, bus.featureVector, exp);
    bus.featureReady = 1'b1;
    @(negedge clk);
    bus.featureReady = 1'b0;
  endtask
  initial begin
    logic [15:0] w;
    bus.spiSck = 1'b0;
    bus.spiMosi = 1'b0;
    bus.spiTransferDone = 1'b0;
    bus.featureReady = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.featureValid, 0);
    chk("rst_vector", bus.featureVector, 0);
    chk("rst_done", bus.frameDone, 0);
    chk("rst_count", bus.frameFeatureCount, 0);
    close_frame("empty", 0, 0, 0);
    chk("empty_valid", bus.featureValid, 0);
    // single word with exact-latency check on the final bit
    bus.featureReady = 1'b1;
    w = 16'h134A;
    send_bits({17'b0, w[15:1]}, 15);
    bus.spiMosi = w[0];
    repeat (3) @(negedge clk);
    bus.spiSck = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat_before_valid", bus.featureValid, 0);
    @(negedge clk);
    chk("lat_valid", bus.featureValid, 1);
    chk("lat_vector", bus.featureVector, 16'h134A);
    @(negedge clk);
    chk("lat_popped", bus.featureValid, 0);
    bus.spiSck = 1'b0;
    bus.featureReady = 1'b0;
    repeat (3) @(negedge clk);
    close_frame("one", 1, 0, 0);
    send_bits(16'h4321, 16);
    send_bits(16'h8765, 16);
    send_bits(16'hCBA9, 16);
    send_bits(16'h0FED, 16);
    close_frame("four", 4, 0, 0);
    pop_check("four0", 16'h4321);
    pop_check("four1", 16'h8765);
    pop_check("four2", 16'hCBA9);
    pop_check("four3", 16'h0FED);
    chk("four_empty", bus.featureValid, 0);
    for (int i = 0; i < 10; i++) send_bits(32'h1000 + i, 16);
    close_frame("ovf", 10, 0, 1);
    for (int i = 0; i < 8; i++) pop_check("ovf_pop", 16'(32'h1000 + i));
    chk("ovf_empty", bus.featureValid, 0);
    send_bits(16'h5555, 16);
    close_frame("clean", 1, 0, 0);
    pop_check("clean_pop", 16'h5555);
    send_bits(16'h2468, 16);
    send_bits(5'b10110, 5);
    close_frame("partial", 1, 1, 0);
    pop_check("partial_pop", 16'h2468);
    chk("partial_empty", bus.featureValid, 0);
    send_bits(16'h9C3E, 16);
    close_frame("realign", 1, 0, 0);
    pop_check("realign_pop", 16'h9C3E);
    send_bits(16'h1111, 16);
    send_bits(16'hAF38 >> 9, 7);
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", bus.featureValid, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", bus.featureValid, 0);
    chk("midrst_vector", bus.featureVector, 0);
    chk("midrst_count", bus.frameFeatureCount, 0);
    chk("midrst_partial", bus.frameErrorPartial, 0);
    chk("midrst_overflow", bus.frameErrorOverflow, 0);
    chk("midrst_done", bus.frameDone, 0);
    repeat (3) @(negedge clk);
    close_frame("post_rst_empty", 0, 0, 0);
    send_bits(16'hAF38, 16);
    close_frame("post_rst", 1, 0, 0);
    pop_check("post_rst_pop", 16'hAF38);
    chk("final_empty", bus.featureValid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/feature_receiver_spi.md
# feature_receiver_spi

SPI receiver for the feature-transfer link: the far end of `featureTransferSpi`, clocked entirely in the system domain. It oversamples `spiSck` and `spiMosi`, reassembles feature vectors of `(NUM_BITS_X + NUM_BITS_Y) * 2` bits, and buffers them in a small show-ahead FIFO. It closes each frame on `spiTransferDone` and reports the per-frame feature count and error flags. It serves as the board-side decoder in loopback and bring-up benches and feeds downstream consumers through a valid/ready port.

## Interface
- `NUM_BITS_X`, 4, bits of X coordinate per corner; `FEATURE_WIDTH = (NUM_BITS_X + NUM_BITS_Y) * 2`
- `NUM_BITS_Y`, 4, bits of Y coordinate per corner
- `FIFO_DEPTH`, 8, feature FIFO entries; power of two, ≥ 2
- `COUNT_WIDTH`, 8, width of the per-frame feature counter
- `systemClock`  in  1  sole clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high; one clock, one reset, as decided
- `spiSck`  in  1  SPI clock from transmitter, asynchronous; mode 0, idles low
- `spiMosi`  in  1  SPI data, asynchronous, MSB first, sampled on `spiSck` rising edge
- `spiTransferDone`  in  1  end-of-frame level/pulse from transmitter, asynchronous
- `featureVector`  out  FEATURE_WIDTH  FIFO head word
- `featureValid`  out  1  FIFO not empty
- `featureReady`  in  1  consumer pop; pop occurs when `featureValid & featureReady`
- `frameDone`  out  1  one-cycle pulse at frame close
- `frameFeatureCount`  out  COUNT_WIDTH  complete words received in the closed frame; held until next `frameDone`
- `frameErrorPartial`  out  1  closed frame ended mid-word; held
- `frameErrorOverflow`  out  1  one or more words dropped on full FIFO in the closed frame; held

## Operation
- Synchronizers: `spiSck`, `spiMosi` and `spiTransferDone` each pass through a 2-flop synchronizer. Edge detectors compare the synchronizer output against a registered previous value.
- Shift path: on each detected `spiSck` rise, shift the synchronized MOSI bit into the LSB and increment `bitCount` (0..FEATURE_WIDTH-1).
- Word completion: at the rise where `bitCount == FEATURE_WIDTH-1`:
  - push `{shift[FEATURE_WIDTH-2:0], mosi}` into the FIFO;
  - reset `bitCount` to 0;
  - increment `wordCount`, saturating at 2^COUNT_WIDTH-1.
- Full FIFO: if the FIFO is full and no pop occurs in the same cycle, the push is dropped and `overflowSticky` is set. `wordCount` still increments.
- Simultaneous push and pop at full: both succeed, occupancy unchanged. Push and pop at empty: the pushed word becomes head next cycle.
- Frame close (rise of synchronized `spiTransferDone`), in one cycle:
  - `frameDone` = 1;
  - `frameFeatureCount` ← `wordCount`;
  - `frameErrorPartial` ← (`bitCount != 0`), and any partial word is discarded;
  - `frameErrorOverflow` ← `overflowSticky`;
  - clear `bitCount`, `wordCount` and `overflowSticky`.
  - An empty frame (no sck edges) closes with count 0 and no errors.
- Coincident events: an sck rise and a transferDone rise in the same cycle process the bit first; the frame then closes including that bit.
- FIFO contents are not cleared at frame close. The consumer drains across frames.

## Timing
- Reset values: `featureValid`=0, `featureVector`=0, `frameDone`=0, `frameFeatureCount`=0, both error flags=0. Also cleared: FIFO, `bitCount`, `wordCount`, sticky flags, synchronizer and edge registers (all to 0).
- `spiSck` high and low phases are each ≥ 2 `systemClock` periods. MOSI is stable ≥ 2 `systemClock` periods around the sck rising edge. The design relies on matched synchronizer depth and does not check these constraints.
- Latency: the last sck rise of a word at the pin produces `featureValid`=1 with the word on `featureVector` after exactly 4 `systemClock` rising edges when the FIFO was empty.
- `frameDone` pulses 4 cycles after the `spiTransferDone` rise at the pin. It never lasts more than 1 cycle, even if `spiTransferDone` stays high.
- A pop updates `featureVector`/`featureValid` on the next cycle (show-ahead).
- Reset mid-frame: all state is dropped on the next edge. A transmitter still mid-word desynchronizes word alignment until its next `spiTransferDone`, and that frame reports `frameErrorPartial` if the bit count is not a multiple of the width.

## Test plan
- Reset, then `spiTransferDone` pulse with no sck -> `frameDone` once, count 0, both errors 0, `featureValid` 0.
- Frame with one word 0x134A, `featureReady`=1 -> `featureVector`=0x134A, valid for 1 cycle 4 cycles after the 16th sck rise; frame count 1, no errors.
- Four words 0x4321, 0x8765, 0xCBA9, 0x0FED with `featureReady`=0, then drain -> popped in that order; count 4.
- FIFO_DEPTH=8, 10 words with `featureReady`=0 -> first 8 retained; count 10; `frameErrorOverflow`=1; next clean frame clears the flag.
- 0x2468 followed by 5 extra bits, then done -> one word 0x2468; count 1; `frameErrorPartial`=1; the next frame's first word is aligned correctly.
- Reset asserted after 7 bits of a word -> outputs return to reset values; the following full frame of 0xAF38 is received intact.
